// File: rtl/minirv_pkg.sv
// Shared miniRV pipeline constants and fetch state encodings.
// Imported by the fetch stage and its IF/ID register.
package minirv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FS_BOOT = 1'b0,
        FS_RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ifid_reg.sv
// IF/ID pipeline register: flush beats hold beats load.
// A flush turns the slot into an invalid NOP; pc is left as-is.
module ifid_reg
    import minirv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = minirv_pkg::NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            hold,
    input  logic [XLEN-1:0] inst_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic            valid_d,
    output logic [XLEN-1:0] inst_q,
    output logic [XLEN-1:0] pc_q,
    output logic            valid_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else if (flush) begin
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (!hold) begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/ifetch.sv
// miniRV fetch stage: fetch PC, ROM addressing and IF/ID register.
// Optional IFETCH_PERF_EN adds fetch and bubble counters.
module ifetch
    import minirv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = minirv_pkg::NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] irom_addr_o,
    input  logic [XLEN-1:0] irom_data_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic            valid_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_o,
    output logic [XLEN-1:0] perf_bubble_o
`endif
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic            f_valid_q;
    logic            redirect_eff;
    logic [XLEN-1:0] id_inst;
    logic [XLEN-1:0] id_pc;
    logic            id_valid;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc_i[1:0];
    assign redirect_eff = redirect_i && (state_q == FS_RUN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FS_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Re-addressing pc_q while stalled keeps irom_data_i stable.
    always_comb begin
        state_d     = state_q;
        irom_addr_o = pc_q + 32'd4;
        unique case (state_q)
            FS_BOOT: begin
                state_d     = FS_RUN;
                irom_addr_o = pc_q;
            end
            FS_RUN: begin
                if (redirect_i) begin
                    irom_addr_o = {redirect_pc_i[XLEN-1:2], 2'b00};
                end else if (stall_i) begin
                    irom_addr_o = pc_q;
                end
            end
            default: state_d = FS_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q      <= RESET_PC;
            f_valid_q <= 1'b0;
        end else begin
            pc_q      <= irom_addr_o;
            f_valid_q <= 1'b1;
        end
    end

    ifid_reg #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_ifid (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .flush   (redirect_eff),
        .hold    (stall_i),
        .inst_d  (irom_data_i),
        .pc_d    (pc_q),
        .valid_d (f_valid_q),
        .inst_q  (id_inst),
        .pc_q    (id_pc),
        .valid_q (id_valid)
    );

    assign inst_o  = id_valid ? id_inst : NOP_INST;
    assign pc_o    = id_pc;
    assign pc4_o   = id_pc + 32'd4;
    assign valid_o = id_valid;

`ifdef IFETCH_PERF_EN
    logic [XLEN-1:0] perf_fetch_q;
    logic [XLEN-1:0] perf_bubble_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_fetch_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            if (!redirect_eff && !stall_i && f_valid_q) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (state_q == FS_RUN && !id_valid) begin
                perf_bubble_q <= perf_bubble_q + 32'd1;
            end
        end
    end

    assign perf_fetch_o  = perf_fetch_q;
    assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch with a 1-cycle synchronous ROM model.
// Build with IFETCH_PERF_EN to also check the perf counters.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] irom_addr;
    logic [31:0] irom_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic        prev_hold = 1'b0;

    ifetch dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .irom_addr_o   (irom_addr),
        .irom_data_i   (irom_data),
        .inst_o        (inst),
        .pc_o          (pc),
        .pc4_o         (pc4),
        .valid_o       (valid)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_bubble_o (perf_bubble)
`endif
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) irom_data <= rom(irom_addr);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_inst", inst, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_addr", irom_addr, 32'h0);
    endtask

    // A held slot shows the same instruction again; pop only new ones.
    always @(posedge clk) prev_hold = stall & ~redirect;

    always @(negedge clk) begin
        if (rst_n && valid && !prev_hold) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_inst", inst, rom(e));
                chk("sb_pc4", pc4, e + 32'd4);
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        chk_reset_outs();

        // Boot, sequential fetch, 3-cycle stall at pc 8
        for (int i = 0; i <= 8; i++) exp_q.push_back(32'(i * 4));
        rst_n = 1'b1;
        #1;
        chk("c1_addr", irom_addr, 32'h0);
        chk("c1_valid", {31'b0, valid}, 32'h0);
        tick();
        chk("c2_inst", inst, NOP);
        chk("c2_valid", {31'b0, valid}, 32'h0);
        chk("c2_addr", irom_addr, 32'h4);
        tick();
        chk("c3_inst", inst, 32'h1000_0000);
        chk("c3_pc", pc, 32'h0);
        chk("c3_pc4", pc4, 32'h4);
        chk("c3_valid", {31'b0, valid}, 32'h1);
        tick();
        tick();
        chk("c5_pc", pc, 32'h8);
        stall = 1'b1;
        #1;
        chk("stall_addr", irom_addr, 32'hC);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_pc", pc, 32'h8);
            chk("stall_inst", inst, rom(32'h8));
            chk("stall_addr_h", irom_addr, 32'hC);
        end
        tick();
        stall = 1'b0;
        #1;
        chk("stall_last_pc", pc, 32'h8);
        chk("rel_addr", irom_addr, 32'h10);
        tick();
        chk("rel_pc", pc, 32'hC);
        chk("rel_inst", inst, rom(32'hC));
        repeat (5) tick();
        chk("mid_pc", pc, 32'h20);

        // Async reset between edges
        #6;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        chk("sb_left_a", 32'(exp_q.size()), 32'd0);

        // Restart; redirect during BOOT must be ignored
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        tick();
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        #1;
        chk("boot_redir_addr", irom_addr, 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        chk("boot_c2_addr", irom_addr, 32'h4);
        chk("boot_c2_valid", {31'b0, valid}, 32'h0);
        tick();
        tick();
        tick();
        chk("redir_pc8", pc, 32'h8);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        chk("redir_addr", irom_addr, 32'h40);
        tick();
        redirect = 1'b0;
        chk("bub_valid", {31'b0, valid}, 32'h0);
        chk("bub_inst", inst, NOP);
        tick();
        chk("tgt_pc", pc, 32'h40);
        chk("tgt_inst", inst, rom(32'h40));
        tick();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 32'h42;
        #1;
        chk("rs_addr", irom_addr, 32'h40);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("rs_bub_valid", {31'b0, valid}, 32'h0);
        tick();
        chk("rs_pc", pc, 32'h40);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("wrap_bub", {31'b0, valid}, 32'h0);
        tick();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 32'h0);
        tick();
        chk("wrap_next", pc, 32'h0);
        @(negedge clk);
        #1;
        chk("sb_left_b", 32'(exp_q.size()), 32'd0);

        // Free run of 10 edges after reset, then one redirect
        rst_n = 1'b0;
        for (int i = 0; i <= 8; i++) exp_q.push_back(32'(i * 4));
        exp_q.push_back(32'h100);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("run10_pc", pc, 32'h20);
`ifdef IFETCH_PERF_EN
        chk("perf_fetch10", perf_fetch, 32'd9);
        chk("perf_bubble10", perf_bubble, 32'd1);
`endif
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("c12_valid", {31'b0, valid}, 32'h0);
        tick();
        chk("c13_pc", pc, 32'h100);
`ifdef IFETCH_PERF_EN
        chk("perf_bubble_r", perf_bubble, 32'd2);
        chk("perf_fetch_r", perf_fetch, 32'd10);
`endif
        @(negedge clk);
        #1;
        chk("sb_left_c", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
